pingpong_ctrl: RTL and testbench
================================

PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, 10, buffer address width.
REQ-002 SHALL have parameter DEPTH, 1024, words per bank.
REQ-003 SHALL have ports as listed:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse, begins a job
- cfg_tile_len  in  ADDR_W+1  words per tile, legal 1..DEPTH
- cfg_num_tiles  in  16  tiles per job
- busy  out  1  job in progress
- done  out  1  one-cycle pulse, job complete
- cfg_err  out  1  sticky, illegal config seen at start
- ld_valid  in  1  loader offers a word
- ld_ready  out  1  controller accepts a loader word
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  buffer write address
- cmp_ready  in  1  consumer requests a word
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  buffer read address
- rd_valid  out  1  buffer rd_data valid this cycle
- switch_banks  out  1  one-cycle bank toggle to buffer

Function
REQ-004 SHALL sample cfg_tile_len and cfg_num_tiles on start in IDLE; start outside IDLE SHALL be ignored.
REQ-005 SHALL treat start with cfg_tile_len of 0 or greater than DEPTH as illegal: set cfg_err, stay IDLE, no done.
REQ-006 SHALL, on legal start with cfg_num_tiles of 0, pulse done the next cycle and stay IDLE.
REQ-007 SHALL implement states IDLE, RUN, FINISH: IDLE->RUN on legal non-zero start; RUN->FINISH when consumed tiles equal num_tiles; FINISH->IDLE unconditionally, done=1 in FINISH only.
REQ-008 SHALL assert busy in RUN and FINISH.
REQ-009 SHALL track wr_cnt (words in write bank) and rd_cnt (words drained from read bank), each ADDR_W+1 bits, plus flag rd_full (read bank holds an undrained tile).
REQ-010 SHALL drive ld_ready=1 in RUN when wr_cnt<tile_len, tiles_loaded<num_tiles and switch_banks=0.
REQ-011 SHALL drive wr_en = ld_valid & ld_ready, wr_addr = wr_cnt[ADDR_W-1:0], and increment wr_cnt on wr_en.
REQ-012 SHALL drive rd_en = cmp_ready & rd_full & (rd_cnt<tile_len) & ~switch_banks in RUN, rd_addr = rd_cnt[ADDR_W-1:0], and increment rd_cnt on rd_en.
REQ-013 SHALL register rd_valid as rd_en delayed one cycle, matching the buffer's one-cycle read latency; the consumer SHALL take data on rd_valid without back-pressure.
REQ-014 SHALL pulse switch_banks for one cycle when wr_cnt==tile_len and (rd_full==0 or rd_cnt==tile_len); in that cycle wr_en and rd_en SHALL be 0.
REQ-015 SHALL, on the cycle after switch_banks, have wr_cnt=0, rd_cnt=0, rd_full=1, tiles_loaded incremented.
REQ-016 SHALL count a tile consumed when rd_cnt reaches tile_len and clear rd_full on that count.
REQ-017 SHALL issue no further switch_banks after the last tile is switched to the read side.
REQ-018 SHALL allow wr_en and rd_en in the same cycle (different banks).

Reset
REQ-019 SHALL, on rst_n low at any time, asynchronously return to IDLE with all counters, rd_full, busy, done, cfg_err, ld_ready, wr_en, rd_en, rd_valid, switch_banks at 0.
REQ-020 SHALL share rst_n with the buffer so both bank selects and controller state restart aligned; an in-flight job is abandoned, no done.

Structure
REQ-021 SHALL place state encoding and ADDR_W/DEPTH defaults in the shared memory package.
REQ-022 SHALL be a single module; no sub-module.

Verification
REQ-023 tile_len=4, num_tiles=1, ld_valid and cmp_ready held 1 -> 4 writes at addr 0..3, switch_banks pulse, 4 reads addr 0..3, rd_valid lags rd_en 1 cycle, one done.
REQ-024 tile_len=8, num_tiles=3, both sides always active -> exactly 3 switch_banks pulses, tile 2 load overlaps tile 1 drain, 24 reads total, done once.
REQ-025 tile_len=4, num_tiles=2, cmp_ready=0 -> after tile 1 loads, ld_ready drops, no second switch until cmp_ready set, then drain and done.
REQ-026 start with cfg_tile_len=0 then with 1025 -> cfg_err=1, busy stays 0, no done; cfg_num_tiles=0 legal -> done pulse next cycle.
REQ-027 rst_n low during mid-tile drain -> all outputs 0 same cycle; fresh tile_len=2, num_tiles=1 job then completes normally.

Source files
------------

// File: rtl/pingpong_ctrl_pkg.sv
// pingpong_ctrl_pkg: shared buffer geometry defaults and controller state encoding
package pingpong_ctrl_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DEPTH  = 1024;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} state_t;
endpackage

// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl: ping-pong buffer controller overlapping tile load with tile drain
module pingpong_ctrl
    import pingpong_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   cfg_tile_len,
    input  logic [15:0]       cfg_num_tiles,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              cmp_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              switch_banks
);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
    state_t state, state_nxt;
    logic [ADDR_W:0] tile_len, wr_cnt, rd_cnt;
    logic [15:0] num_tiles, tiles_loaded, tiles_done;
    logic rd_full, zero_done, in_run, start_bad, start_ok, last_rd;
    assign in_run    = state == ST_RUN;
    assign start_bad = state == ST_IDLE && start && (cfg_tile_len == '0 || cfg_tile_len > MAX_LEN);
    assign start_ok  = state == ST_IDLE && start && !start_bad;
    assign last_rd   = rd_en && (rd_cnt + CNT_ONE == tile_len);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_nxt;
    end

    // next state: a zero-tile job never leaves IDLE, FINISH lasts exactly one cycle
    always_comb begin
        state_nxt = state == ST_IDLE ? (start_ok && cfg_num_tiles != '0 ? ST_RUN : ST_IDLE) :
                    state == ST_RUN  ? (tiles_done == num_tiles ? ST_FINISH : ST_RUN) : ST_IDLE;
    end

    // outputs: the bank switch cycle blocks both buffer ports
    always_comb begin
        busy         = state != ST_IDLE;
        done         = state == ST_FINISH || zero_done;
        switch_banks = in_run && wr_cnt == tile_len && tiles_loaded < num_tiles &&
                       (!rd_full || rd_cnt == tile_len);
        ld_ready     = in_run && wr_cnt < tile_len && tiles_loaded < num_tiles && !switch_banks;
        wr_en        = ld_valid && ld_ready;
        wr_addr      = wr_cnt[ADDR_W-1:0];
        rd_en        = in_run && cmp_ready && rd_full && rd_cnt < tile_len && !switch_banks;
        rd_addr      = rd_cnt[ADDR_W-1:0];
    end

    // job config capture, sticky config error, zero-tile done and read-valid pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_len  <= '0;
            num_tiles <= '0;
            cfg_err   <= 1'b0;
            zero_done <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            tile_len  <= start_ok ? cfg_tile_len : tile_len;
            num_tiles <= start_ok ? cfg_num_tiles : num_tiles;
            cfg_err   <= cfg_err | start_bad;
            zero_done <= start_ok && cfg_num_tiles == '0;
            rd_valid  <= rd_en;
        end
    end

    // bank fill/drain counters; a bank switch rearms both sides on the swapped banks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            rd_full      <= 1'b0;
            tiles_loaded <= '0;
            tiles_done   <= '0;
        end else if (start_ok) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            rd_full      <= 1'b0;
            tiles_loaded <= '0;
            tiles_done   <= '0;
        end else if (switch_banks) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            rd_full      <= 1'b1;
            tiles_loaded <= tiles_loaded + 16'd1;
        end else begin
            wr_cnt       <= wr_en ? wr_cnt + CNT_ONE : wr_cnt;
            rd_cnt       <= rd_en ? rd_cnt + CNT_ONE : rd_cnt;
            rd_full      <= rd_full && !last_rd;
            tiles_done   <= last_rd ? tiles_done + 16'd1 : tiles_done;
        end
    end
endmodule

// File: tb/tb_pingpong_ctrl.sv
// tb_pingpong_ctrl: randomized bench with a two-bank buffer model and in-order data scoreboard
`timescale 1ns/1ps
module tb_pingpong_ctrl;
    localparam int AW = 10;
    localparam int DP = 1024;
    typedef struct {int wr; int rd; int rv; int sw; int dn; int both; int viol;} stats_t;
    bit clk;
    logic rst_n, start, ld_valid, cmp_ready;
    logic [AW:0] cfg_tile_len;
    logic [15:0] cfg_num_tiles, ld_data, rd_q;
    logic busy, done, cfg_err, ld_ready, wr_en, rd_en, rd_valid, switch_banks;
    logic [AW-1:0] wr_addr, rd_addr;
    int ld_mode, cmp_mode, cur_len;
    int checks, failures;
    int n_wr, n_rd, n_rv, n_sw, n_done, n_both, viol, w_idx, r_idx;
    bit wsel, prev_rd;
    logic [15:0] mem [2][DP];
    logic [15:0] exp_q[$];

    pingpong_ctrl #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_tile_len(cfg_tile_len),
        .cfg_num_tiles(cfg_num_tiles), .busy(busy), .done(done), .cfg_err(cfg_err),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .cmp_ready(cmp_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .switch_banks(switch_banks)
    );

    always #5 clk = ~clk;

    // loader and consumer drivers: 0 = held active / 1 = random for loader, 0 = idle / 1 = active / 2 = random for consumer
    always @(posedge clk) begin
        #1;
        ld_valid  = ld_mode == 0 ? 1'b1 : ld_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
        cmp_ready = cmp_mode == 1 ? 1'b1 : cmp_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
        ld_data   = 16'($urandom);
    end

    // buffer + scoreboard model: words must come out in the order they went in, each tile at addresses 0..len-1
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            wsel = 0; w_idx = 0; r_idx = 0; prev_rd = 0; exp_q.delete();
        end else begin
            if (start && !busy) begin w_idx = 0; r_idx = 0; exp_q.delete(); end
            if (rd_valid !== prev_rd) viol++;
            if (rd_valid === 1'b1) begin
                n_rv++;
                if (exp_q.size() == 0) viol++;
                else begin
                    if (rd_q !== exp_q[0]) viol++;
                    void'(exp_q.pop_front());
                end
            end
            if (wr_en !== (ld_valid & ld_ready)) viol++;
            if (switch_banks === 1'b1 && (wr_en !== 1'b0 || rd_en !== 1'b0)) viol++;
            if (wr_en === 1'b1) begin
                if (wr_addr !== AW'(w_idx) || w_idx >= cur_len) viol++;
                mem[wsel][wr_addr] = ld_data;
                exp_q.push_back(ld_data);
                w_idx++; n_wr++;
            end
            if (rd_en === 1'b1) begin
                if (rd_addr !== AW'(r_idx) || r_idx >= cur_len) viol++;
                rd_q = mem[!wsel][rd_addr];
                r_idx++; n_rd++;
            end
            if (wr_en === 1'b1 && rd_en === 1'b1) n_both++;
            if (switch_banks === 1'b1) begin
                if (w_idx != cur_len) viol++;
                wsel = !wsel; w_idx = 0; r_idx = 0; n_sw++;
            end
            if (done === 1'b1) n_done++;
            prev_rd = rd_en;
        end
    end

    function automatic stats_t snap();
        stats_t s;
        s.wr = n_wr; s.rd = n_rd; s.rv = n_rv; s.sw = n_sw; s.dn = n_done; s.both = n_both; s.viol = viol;
        return s;
    endfunction

    function automatic stats_t delta(stats_t b);
        stats_t s = snap();
        s.wr -= b.wr; s.rd -= b.rd; s.rv -= b.rv; s.sw -= b.sw; s.dn -= b.dn; s.both -= b.both; s.viol -= b.viol;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int len, input int num);
        cur_len = len;
        cfg_tile_len = (AW+1)'(len);
        cfg_num_tiles = 16'(num);
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int base, input int bound, output bit to);
        int c = 0;
        while (n_done == base && c < bound) begin tick(); c++; end
        to = n_done == base;
    endtask

    task automatic test_reset();
        rst_n = 0; ld_mode = 0; cmp_mode = 1;
        repeat (3) tick();
        checks++;
        if ({busy, done, cfg_err, ld_ready, wr_en, rd_en, rd_valid, switch_banks} !== 8'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000000", {busy, done, cfg_err, ld_ready, wr_en, rd_en, rd_valid, switch_banks});
        end
        rst_n = 1;
        tick();
        checks++;
        if ({busy, ld_ready, rd_en, switch_banks} !== 4'b0) begin
            failures++; $display("FAIL idle_after_reset got=%b exp=0000", {busy, ld_ready, rd_en, switch_banks});
        end
    endtask

    task automatic test_single();
        stats_t b = snap(), d;
        bit to;
        ld_mode = 0; cmp_mode = 1;
        kick(4, 1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        wait_done(b.dn, 200, to);
        tick(); tick();
        d = delta(b);
        checks++; if (to) begin failures++; $display("FAIL single_timeout got=no_done exp=done"); end
        checks++; if (d.wr != 4) begin failures++; $display("FAIL single_writes got=%0d exp=4", d.wr); end
        checks++; if (d.rd != 4 || d.rv != 4) begin failures++; $display("FAIL single_reads got=%0d/%0d exp=4/4", d.rd, d.rv); end
        checks++; if (d.sw != 1) begin failures++; $display("FAIL single_switch got=%0d exp=1", d.sw); end
        checks++; if (d.dn != 1) begin failures++; $display("FAIL single_done got=%0d exp=1", d.dn); end
        checks++; if (d.viol != 0 || exp_q.size() != 0) begin failures++; $display("FAIL single_protocol got=%0d/%0d exp=0/0", d.viol, exp_q.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_three();
        stats_t b = snap(), d;
        bit to;
        ld_mode = 0; cmp_mode = 1;
        kick(8, 3);
        wait_done(b.dn, 400, to);
        tick(); tick();
        d = delta(b);
        checks++; if (to) begin failures++; $display("FAIL three_timeout got=no_done exp=done"); end
        checks++; if (d.sw != 3) begin failures++; $display("FAIL three_switch got=%0d exp=3", d.sw); end
        checks++; if (d.rd != 24 || d.wr != 24) begin failures++; $display("FAIL three_words got=%0d/%0d exp=24/24", d.wr, d.rd); end
        checks++; if (d.dn != 1) begin failures++; $display("FAIL three_done got=%0d exp=1", d.dn); end
        checks++; if (d.both < 1) begin failures++; $display("FAIL three_overlap got=%0d exp=>0", d.both); end
        checks++; if (d.viol != 0) begin failures++; $display("FAIL three_protocol got=%0d exp=0", d.viol); end
    endtask

    task automatic test_backpressure();
        stats_t b = snap(), d;
        bit to;
        ld_mode = 0; cmp_mode = 0;
        kick(4, 2);
        repeat (30) tick();
        d = delta(b);
        checks++; if (d.sw != 1) begin failures++; $display("FAIL bp_switch_hold got=%0d exp=1", d.sw); end
        checks++; if (d.wr != 8) begin failures++; $display("FAIL bp_writes got=%0d exp=8", d.wr); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL bp_ld_ready got=%b exp=0", ld_ready); end
        checks++; if (d.dn != 0 || busy !== 1'b1) begin failures++; $display("FAIL bp_pending got=%0d/%b exp=0/1", d.dn, busy); end
        cmp_mode = 1;
        wait_done(b.dn, 200, to);
        tick(); tick();
        d = delta(b);
        checks++; if (to) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
        checks++; if (d.sw != 2 || d.rd != 8) begin failures++; $display("FAIL bp_drain got=%0d/%0d exp=2/8", d.sw, d.rd); end
        checks++; if (d.dn != 1 || d.viol != 0) begin failures++; $display("FAIL bp_finish got=%0d/%0d exp=1/0", d.dn, d.viol); end
    endtask

    task automatic test_boundary();
        stats_t b = snap(), d;
        bit to;
        ld_mode = 0; cmp_mode = 1;
        kick(DP, 1);
        wait_done(b.dn, 5000, to);
        tick(); tick();
        d = delta(b);
        checks++; if (to) begin failures++; $display("FAIL maxlen_timeout got=no_done exp=done"); end
        checks++; if (d.wr != DP || d.rd != DP) begin failures++; $display("FAIL maxlen_words got=%0d/%0d exp=%0d", d.wr, d.rd, DP); end
        checks++; if (d.sw != 1 || d.dn != 1 || d.viol != 0) begin failures++; $display("FAIL maxlen_misc got=%0d/%0d/%0d exp=1/1/0", d.sw, d.dn, d.viol); end
        b = snap();
        ld_mode = 1; cmp_mode = 2;
        kick(1, 3);
        wait_done(b.dn, 500, to);
        tick(); tick();
        d = delta(b);
        checks++; if (to) begin failures++; $display("FAIL len1_timeout got=no_done exp=done"); end
        checks++; if (d.rd != 3 || d.sw != 3 || d.dn != 1 || d.viol != 0) begin
            failures++; $display("FAIL len1_job got=%0d/%0d/%0d/%0d exp=3/3/1/0", d.rd, d.sw, d.dn, d.viol);
        end
    endtask

    task automatic test_reset_mid();
        stats_t b = snap(), d;
        bit to;
        int c = 0;
        ld_mode = 0; cmp_mode = 1;
        kick(8, 2);
        while (n_rd - b.rd < 3 && c < 100) begin tick(); c++; end
        checks++; if (n_rd - b.rd < 3) begin failures++; $display("FAIL midrst_drain got=%0d exp=>=3", n_rd - b.rd); end
        #1 rst_n = 0;
        #1;
        checks++;
        if ({busy, done, cfg_err, ld_ready, wr_en, rd_en, rd_valid, switch_banks} !== 8'b0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b exp=00000000", {busy, done, cfg_err, ld_ready, wr_en, rd_en, rd_valid, switch_banks});
        end
        repeat (3) tick();
        rst_n = 1;
        repeat (5) tick();
        d = delta(b);
        checks++; if (d.dn != 0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_abandon got=%0d/%b exp=0/0", d.dn, busy); end
        b = snap();
        kick(2, 1);
        wait_done(b.dn, 200, to);
        tick(); tick();
        d = delta(b);
        checks++; if (to) begin failures++; $display("FAIL midrst_timeout got=no_done exp=done"); end
        checks++; if (d.wr != 2 || d.rd != 2 || d.sw != 1 || d.dn != 1 || d.viol != 0) begin
            failures++; $display("FAIL midrst_fresh got=%0d/%0d/%0d/%0d/%0d exp=2/2/1/1/0", d.wr, d.rd, d.sw, d.dn, d.viol);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            stats_t b = snap(), d;
            bit to;
            int len = $urandom_range(1, 12);
            int num = $urandom_range(0, 4);
            ld_mode = 1; cmp_mode = 2;
            kick(len, num);
            wait_done(b.dn, 3000, to);
            tick(); tick();
            d = delta(b);
            checks++; if (to) begin failures++; $display("FAIL rand%0d_timeout got=no_done exp=done", j); end
            checks++; if (d.wr != len * num || d.rd != len * num || d.rv != len * num) begin
                failures++; $display("FAIL rand%0d_words got=%0d/%0d/%0d exp=%0d", j, d.wr, d.rd, d.rv, len * num);
            end
            checks++; if (d.sw != num) begin failures++; $display("FAIL rand%0d_switch got=%0d exp=%0d", j, d.sw, num); end
            checks++; if (d.dn != 1) begin failures++; $display("FAIL rand%0d_done got=%0d exp=1", j, d.dn); end
            checks++; if (d.viol != 0 || exp_q.size() != 0) begin
                failures++; $display("FAIL rand%0d_protocol got=%0d/%0d exp=0/0", j, d.viol, exp_q.size());
            end
        end
    endtask

    task automatic test_cfg_err();
        stats_t b = snap(), d;
        ld_mode = 0; cmp_mode = 1;
        kick(0, 3);
        repeat (3) tick();
        checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL cfg_len0 got=%b/%b exp=1/0", cfg_err, busy); end
        kick(DP + 1, 3);
        repeat (3) tick();
        d = delta(b);
        checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL cfg_len_big got=%b/%b exp=1/0", cfg_err, busy); end
        checks++; if (d.dn != 0 || d.wr != 0) begin failures++; $display("FAIL cfg_no_job got=%0d/%0d exp=0/0", d.dn, d.wr); end
        kick(4, 0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_tiles_done got=%b/%b exp=1/0", done, busy); end
        tick();
        checks++; if (done !== 1'b0 || cfg_err !== 1'b1) begin failures++; $display("FAIL zero_tiles_after got=%b/%b exp=0/1", done, cfg_err); end
    endtask

    initial begin
        rst_n = 0; start = 0; cfg_tile_len = '0; cfg_num_tiles = '0;
        ld_mode = 0; cmp_mode = 1; cur_len = 0;
        test_reset();
        test_single();
        test_three();
        test_backpressure();
        test_boundary();
        test_reset_mid();
        test_random();
        test_cfg_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
